// File: rtl/iq_word_packer_pkg.sv
// Shared types and constants for the GPS IQ nibble packer.
package iq_word_packer_pkg;

  localparam int unsigned NIBBLE_W = 4;

  // Bit positions within the captured nibble {I1, I0, Q1, Q0}
  localparam int unsigned I1_POS = 3;
  localparam int unsigned I0_POS = 2;
  localparam int unsigned Q1_POS = 1;
  localparam int unsigned Q0_POS = 0;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    FILLING  = 2'd2
  } pack_state_t;

  function automatic int unsigned npw(input int unsigned word_w);
    return word_w / NIBBLE_W;
  endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data always presents the head entry.
module iq_sync_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot, so a push is accepted even when full
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iq_word_packer.sv
// Packs 4-bit GPS IQ samples MSB-first into words, buffers them and counts dropped words.
module iq_word_packer
  import iq_word_packer_pkg::*;
#(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVF_W      = 8
) (
  input  logic                          MCU_CLK_25_000,
  input  logic                          RESET_N,
  input  logic                          GPS_I0,
  input  logic                          GPS_I1,
  input  logic                          GPS_Q0,
  input  logic                          GPS_Q1,
  input  logic                          DATAREADY,
  input  logic                          ENABLE,
  output logic [WORD_W-1:0]             WORD_DATA,
  output logic                          WORD_VALID,
  input  logic                          WORD_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic [OVF_W-1:0]              OVF_COUNT,
  input  logic                          OVF_CLEAR
);

  localparam int unsigned NPW   = npw(WORD_W);
  localparam int unsigned IDX_W = (NPW > 1) ? $clog2(NPW) : 1;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  pack_state_t         state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [WORD_W-1:0]   shift, shift_n;
  logic [WORD_W-1:0]   word_c;
  logic [NIBBLE_W-1:0] nib_c;
  logic                push_c;
  logic                pop_c;
  logic                drop_c;
  logic                full;
  logic                empty;

  always_comb begin
    nib_c         = '0;
    nib_c[I1_POS] = GPS_I1;
    nib_c[I0_POS] = GPS_I0;
    nib_c[Q1_POS] = GPS_Q1;
    nib_c[Q0_POS] = GPS_Q0;
  end

  // Next-state: shift left so the earliest nibble ends up in the top bits
  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
    push_c  = 1'b0;
    word_c  = (shift << NIBBLE_W) | WORD_W'(nib_c);
    if (!ENABLE) begin
      state_n = DISABLED;
      idx_n   = '0;
      shift_n = '0;
    end else begin
      case (state)
        DISABLED: state_n = ARMED;
        ARMED, FILLING: begin
          if (DATAREADY) begin
            state_n = FILLING;
            if (idx == IDX_W'(NPW - 1)) begin
              push_c  = 1'b1;
              idx_n   = '0;
              shift_n = '0;
            end else begin
              idx_n   = idx + IDX_W'(1);
              shift_n = word_c;
            end
          end
        end
        default: state_n = DISABLED;
      endcase
    end
  end

  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= DISABLED;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  assign WORD_VALID = !empty;
  assign pop_c      = WORD_VALID && WORD_READY;
  assign drop_c     = push_c && full && !pop_c;

  iq_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (MCU_CLK_25_000),
    .rst_n     (RESET_N),
    .push      (push_c),
    .push_data (word_c),
    .pop       (pop_c),
    .rd_data   (WORD_DATA),
    .level     (FIFO_LEVEL),
    .full      (full),
    .empty     (empty)
  );

  // A drop in the same cycle as a clear restarts the count at one
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERFLOW  <= 1'b0;
      OVF_COUNT <= '0;
    end else if (drop_c) begin
      OVERFLOW <= 1'b1;
      if (OVF_CLEAR) begin
        OVF_COUNT <= OVF_W'(1);
      end else if (OVF_COUNT != OVF_MAX) begin
        OVF_COUNT <= OVF_COUNT + OVF_W'(1);
      end
    end else if (OVF_CLEAR) begin
      OVERFLOW  <= 1'b0;
      OVF_COUNT <= '0;
    end
  end

endmodule

// File: tb/tb_iq_word_packer.sv
// Randomized bench for iq_word_packer with a queue-based reference model and directed scenarios.
module tb_iq_word_packer;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned OVF_W  = 8;
  localparam int unsigned NPW    = WORD_W / 4;

  logic              clk;
  logic              rst_n;
  logic              gps_i0, gps_i1, gps_q0, gps_q1;
  logic              dataready;
  logic              enable;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic [3:0]        fifo_level;
  logic              overflow;
  logic [OVF_W-1:0]  ovf_count;
  logic              ovf_clear;

  int n_cmp = 0;
  int n_bad = 0;

  iq_word_packer #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .MCU_CLK_25_000 (clk),
    .RESET_N        (rst_n),
    .GPS_I0         (gps_i0),
    .GPS_I1         (gps_i1),
    .GPS_Q0         (gps_q0),
    .GPS_Q1         (gps_q1),
    .DATAREADY      (dataready),
    .ENABLE         (enable),
    .WORD_DATA      (word_data),
    .WORD_VALID     (word_valid),
    .WORD_READY     (word_ready),
    .FIFO_LEVEL     (fifo_level),
    .OVERFLOW       (overflow),
    .OVF_COUNT      (ovf_count),
    .OVF_CLEAR      (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: nibbles collected while capturing, words in a bounded queue
  bit                m_capturing;
  logic [3:0]        m_parts[$];
  logic [WORD_W-1:0] m_q[$];
  bit                m_ovf;
  int                m_cnt;
  bit                m_pop, m_push;
  logic [WORD_W-1:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_capturing = 1'b0;
      m_parts.delete();
      m_q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      m_pop  = (m_q.size() > 0) && word_ready;
      m_push = 1'b0;
      if (!enable) begin
        m_capturing = 1'b0;
        m_parts.delete();
      end else if (!m_capturing) begin
        m_capturing = 1'b1;
      end else if (dataready) begin
        m_parts.push_back({gps_i1, gps_i0, gps_q1, gps_q0});
        if (m_parts.size() == NPW) begin
          m_word = '0;
          foreach (m_parts[i]) m_word = (m_word << 4) | WORD_W'(m_parts[i]);
          m_push = 1'b1;
          m_parts.delete();
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push && m_q.size() == DEPTH) begin
        m_ovf = 1'b1;
        m_cnt = ovf_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else begin
        if (m_push) m_q.push_back(m_word);
        if (ovf_clear) begin
          m_ovf = 1'b0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", 32'(word_valid), 32'(m_q.size() != 0));
      check("level", 32'(fifo_level), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("ovf_count", 32'(ovf_count), 32'(m_cnt));
      if (m_q.size() != 0) check("data", 32'(word_data), 32'(m_q[0]));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] n);
    {gps_i1, gps_i0, gps_q1, gps_q0} = n;
    dataready = 1'b1;
    @(negedge clk);
    dataready = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int i = NPW - 1; i >= 0; i--) begin
      strobe(w[i*4 +: 4]);
      idle(1);
    end
  endtask

  task automatic drain();
    word_ready = 1'b1;
    idle(DEPTH + 2);
    word_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(word_data), 32'h0);
    check({tag, "_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_level"}, 32'(fifo_level), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
    check({tag, "_cnt"}, 32'(ovf_count), 32'h0);
  endtask

  logic [3:0]        nibs[36];
  logic [WORD_W-1:0] first_w;
  logic [WORD_W-1:0] new_w;

  initial begin
    rst_n = 1'b0; enable = 1'b0; dataready = 1'b0; word_ready = 1'b0; ovf_clear = 1'b0;
    {gps_i1, gps_i0, gps_q1, gps_q0} = 4'h0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Packing order
    enable = 1'b1;
    idle(2);
    strobe(4'hA); idle(1);
    strobe(4'h5); idle(2);
    strobe(4'hC); idle(1);
    check("pre_valid", 32'(word_valid), 32'h0);
    strobe(4'h3);
    check("pack_valid", 32'(word_valid), 32'h1);
    check("pack_data", 32'(word_data), 32'hA5C3);
    check("pack_level", 32'(fifo_level), 32'h1);
    idle(1);

    // Reset mid-fill with one word stored
    strobe(4'h1); idle(1);
    strobe(4'h2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_word(16'h789B);
    check("postrst_data", 32'(word_data), 32'h789B);
    check("postrst_level", 32'(fifo_level), 32'h1);
    drain();

    // Overflow: nine words with the consumer stalled
    foreach (nibs[i]) nibs[i] = 4'($urandom);
    first_w = {nibs[0], nibs[1], nibs[2], nibs[3]};
    foreach (nibs[i]) begin
      strobe(nibs[i]);
      idle(1);
    end
    check("ovf_level", 32'(fifo_level), 32'h8);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_cnt", 32'(ovf_count), 32'h1);
    check("ovf_head", 32'(word_data), 32'(first_w));

    // Full FIFO, push coincides with pop
    new_w = 16'h3E71;
    strobe(4'h3); idle(1);
    strobe(4'hE); idle(1);
    strobe(4'h7); idle(1);
    word_ready = 1'b1;
    strobe(4'h1);
    word_ready = 1'b0;
    check("pp_level", 32'(fifo_level), 32'h8);
    check("pp_cnt", 32'(ovf_count), 32'h1);
    word_ready = 1'b1;
    idle(7);
    word_ready = 1'b0;
    check("pp_last_data", 32'(word_data), 32'(new_w));
    check("pp_last_level", 32'(fifo_level), 32'h1);
    drain();

    // Disable mid-word discards the partial word
    strobe(4'h9); idle(1);
    strobe(4'h9); idle(1);
    strobe(4'h9); idle(1);
    enable = 1'b0; idle(1);
    enable = 1'b1; idle(2);
    send_word(16'h1111);
    check("dis_data", 32'(word_data), 32'h1111);
    check("dis_level", 32'(fifo_level), 32'h1);
    drain();

    // Clear, then clear coincident with a drop, then saturation
    ovf_clear = 1'b1; idle(1); ovf_clear = 1'b0;
    check("clr_flag", 32'(overflow), 32'h0);
    check("clr_cnt", 32'(ovf_count), 32'h0);
    for (int i = 0; i < 13; i++) send_word(16'(i * 16'h1111));
    check("five_cnt", 32'(ovf_count), 32'h5);
    strobe(4'h1); idle(1);
    strobe(4'h2); idle(1);
    strobe(4'h3); idle(1);
    ovf_clear = 1'b1;
    strobe(4'h4);
    ovf_clear = 1'b0;
    check("clrdrop_flag", 32'(overflow), 32'h1);
    check("clrdrop_cnt", 32'(ovf_count), 32'h1);
    for (int i = 0; i < 259; i++) send_word(16'($urandom));
    check("sat_cnt", 32'(ovf_count), 32'hFF);
    check("sat_level", 32'(fifo_level), 32'h8);
    ovf_clear = 1'b1; idle(1); ovf_clear = 1'b0;
    drain();

    // Random traffic, including back-to-back strobes and stalls
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 99) != 0);
      dataready  = ($urandom_range(0, 2) == 0);
      {gps_i1, gps_i0, gps_q1, gps_q0} = 4'($urandom);
      word_ready = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      ovf_clear  = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    dataready = 1'b0; ovf_clear = 1'b0;
    drain();
    check("end_level", 32'(fifo_level), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
